// File: rtl/rain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rain_pkg
// Brief    : Shared constants, slot record and sweep FSM encoding for the
//            glyph-rain column scheduler.
// Revision : 1.0
// ============================================================================
package rain_pkg;

    localparam int DEF_NUM_COLS = 80;
    localparam int DEF_ROWS     = 40;
    localparam int DEF_TRAIL    = 8;

    // Feedback taps b7^b5^b4^b3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic       active;
        logic [5:0] head;
        logic [1:0] speed;
        logic [1:0] phase;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Brief    : 8-bit Fibonacci LFSR that advances only when step is high.
// Revision : 1.0
// ============================================================================
module lfsr8
    import rain_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= seed;
        end else if (step) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rain_column_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rain_column_scheduler
// Brief    : Per-column drop slots swept once per frame, plus a registered
//            trail-distance query port for the pixel pipeline.
// Revision : 1.0
// ============================================================================
module rain_column_scheduler
    import rain_pkg::*;
#(
    parameter int         NUM_COLS = DEF_NUM_COLS,
    parameter int         ROWS     = DEF_ROWS,
    parameter int         TRAIL    = DEF_TRAIL,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [3:0]  density,
    input  logic [6:0]  rd_col,
    input  logic [5:0]  rd_row,
    output logic        rd_hit,
    output logic [2:0]  rd_dist,
    output logic        rd_head,
    output logic        busy,
    output logic        overrun,
    output logic [10:0] frame_cnt
);

    localparam logic [6:0] LAST_IDX  = 7'(NUM_COLS - 1);
    localparam logic [6:0] COL_LIMIT = 7'(NUM_COLS);
    localparam logic [5:0] HEAD_MAX  = 6'(ROWS + TRAIL - 1);
    localparam logic [5:0] TRAIL_LEN = 6'(TRAIL);

    sched_state_t r_state;
    sched_state_t w_state_next;
    logic [6:0]   r_idx;
    logic         w_sweep;
    logic         w_done;
    logic         w_tick_go;
    logic [7:0]   w_lfsr;
    logic         w_unused_lfsr;
    slot_t        r_slots [NUM_COLS];
    slot_t        w_cur;
    slot_t        w_upd;
    logic         w_rd_active;
    logic [5:0]   w_rd_head;
    logic [5:0]   w_rd_t;
    logic         w_rd_hit;

    assign w_tick_go     = frame_tick & enable;
    assign w_unused_lfsr = ^w_lfsr[7:6];

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (w_sweep),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_tick_go) w_state_next = ST_SWEEP;
            ST_SWEEP: if (r_idx == LAST_IDX) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        w_sweep = (r_state == ST_SWEEP);
        w_done  = (r_state == ST_DONE);
    end

    // Ticks that arrive during SWEEP or DONE are dropped but remembered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (!busy && w_tick_go) begin
                r_idx <= '0;
            end else if (w_sweep) begin
                r_idx <= r_idx + 7'd1;
            end
            if (w_done) begin
                frame_cnt <= frame_cnt + 11'd1;
            end
            if (busy && w_tick_go) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_cur = (r_idx < COL_LIMIT) ? r_slots[r_idx] : '0;
        w_upd = w_cur;
        if (w_cur.active) begin
            if (w_cur.phase == w_cur.speed) begin
                w_upd.phase = 2'd0;
                if (w_cur.head == HEAD_MAX) begin
                    w_upd.active = 1'b0;
                end else begin
                    w_upd.head = w_cur.head + 6'd1;
                end
            end else begin
                w_upd.phase = w_cur.phase + 2'd1;
            end
        end else if (w_lfsr[3:0] < density) begin
            w_upd.active = 1'b1;
            w_upd.head   = 6'd0;
            w_upd.speed  = w_lfsr[5:4];
            w_upd.phase  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                r_slots[i] <= '0;
            end
        end else if (w_sweep) begin
            r_slots[r_idx] <= w_upd;
        end
    end

    // The query reads the pre-edge array, so a same-cycle write is not visible
    always_comb begin
        w_rd_active = 1'b0;
        w_rd_head   = '0;
        if (rd_col < COL_LIMIT) begin
            w_rd_active = r_slots[rd_col].active;
            w_rd_head   = r_slots[rd_col].head;
        end
        w_rd_t   = w_rd_head - rd_row;
        w_rd_hit = w_rd_active && (w_rd_head >= rd_row) && (w_rd_t < TRAIL_LEN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_hit  <= 1'b0;
            rd_dist <= '0;
            rd_head <= 1'b0;
        end else begin
            rd_hit  <= w_rd_hit;
            rd_dist <= w_rd_hit ? w_rd_t[2:0] : 3'd0;
            rd_head <= w_rd_hit && (w_rd_t == 6'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rain_column_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rain_column_scheduler
// Brief    : Randomized bench comparing the scheduler with a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_rain_column_scheduler;

    localparam int         NC    = 80;
    localparam int         NR    = 40;
    localparam int         TR    = 8;
    localparam logic [7:0] SEEDV = 8'hA5;
    localparam int         NCYC  = 30000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        enable;
    logic [3:0]  density;
    logic [6:0]  rd_col;
    logic [5:0]  rd_row;
    logic        rd_hit;
    logic [2:0]  rd_dist;
    logic        rd_head;
    logic        busy;
    logic        overrun;
    logic [10:0] frame_cnt;

    always #5 clk = ~clk;

    rain_column_scheduler #(
        .NUM_COLS (NC),
        .ROWS     (NR),
        .TRAIL    (TR),
        .SEED     (SEEDV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .enable     (enable),
        .density    (density),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_hit     (rd_hit),
        .rd_dist    (rd_dist),
        .rd_head    (rd_head),
        .busy       (busy),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Frame-level model: whole frame precomputed at acceptance, columns
    // become visible one per cycle as the sweep passes them.
    bit         m_act [NC];
    int         m_head[NC], m_spd[NC], m_ph[NC];
    bit         p_act [NC];
    int         p_head[NC], p_spd[NC], p_ph[NC];
    bit [7:0]   m_lfsr;
    bit         m_busy, m_ovr;
    int         m_age, m_fcnt;
    int         e_hit, e_dist, e_headf;

    function automatic bit [7:0] lfsr_next(input bit [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic start_frame();
        bit [7:0] r = m_lfsr;
        for (int c = 0; c < NC; c++) begin
            p_act[c] = m_act[c]; p_head[c] = m_head[c];
            p_spd[c] = m_spd[c]; p_ph[c]   = m_ph[c];
            if (m_act[c]) begin
                if (m_ph[c] == m_spd[c]) begin
                    p_ph[c] = 0;
                    if (m_head[c] == NR + TR - 1) p_act[c] = 0;
                    else p_head[c] = m_head[c] + 1;
                end else begin
                    p_ph[c] = m_ph[c] + 1;
                end
            end else if (int'(r[3:0]) < int'(density)) begin
                p_act[c] = 1; p_head[c] = 0; p_spd[c] = int'(r[5:4]); p_ph[c] = 0;
            end
            r = lfsr_next(r);
        end
        m_lfsr = r;
        m_busy = 1;
        m_age  = 0;
    endtask

    task automatic model_edge();
        bit was_busy;
        int c;
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                m_act[i] = 0; m_head[i] = 0; m_spd[i] = 0; m_ph[i] = 0;
            end
            m_lfsr = SEEDV; m_busy = 0; m_age = 0; m_ovr = 0; m_fcnt = 0;
            e_hit = 0; e_dist = 0; e_headf = 0;
            return;
        end
        c = int'(rd_col);
        if (c < NC && m_act[c] && m_head[c] >= int'(rd_row) && m_head[c] - int'(rd_row) < TR) begin
            e_hit = 1; e_dist = m_head[c] - int'(rd_row); e_headf = (e_dist == 0);
        end else begin
            e_hit = 0; e_dist = 0; e_headf = 0;
        end
        was_busy = m_busy;
        if (m_busy) begin
            m_age++;
            if (m_age <= NC) begin
                m_act[m_age-1] = p_act[m_age-1]; m_head[m_age-1] = p_head[m_age-1];
                m_spd[m_age-1] = p_spd[m_age-1]; m_ph[m_age-1]   = p_ph[m_age-1];
            end else begin
                m_fcnt = (m_fcnt + 1) % 2048;
                m_busy = 0;
            end
        end
        if (frame_tick && enable) begin
            if (was_busy) m_ovr = 1;
            else start_frame();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rd_hit",    32'(rd_hit),    32'(e_hit));
        check_eq("rd_dist",   32'(rd_dist),   32'(e_dist));
        check_eq("rd_head",   32'(rd_head),   32'(e_headf));
        check_eq("busy",      32'(busy),      32'(m_busy));
        check_eq("overrun",   32'(overrun),   32'(m_ovr));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    endtask

    // Aim reads near live heads so trails are actually exercised
    task automatic pick_read();
        int c, r;
        c = $urandom_range(0, NC + 7);
        r = $urandom_range(0, NR - 1);
        if (c < NC && m_act[c] && $urandom_range(0, 3) != 0) begin
            r = m_head[c] - $urandom_range(0, TR + 1);
            if (r < 0) r = 0;
            if (r > NR - 1) r = $urandom_range(NR - TR, NR - 1);
        end
        rd_col = 7'(c);
        rd_row = 6'(r);
    endtask

    initial begin
        int dens_tab[8] = '{0, 1, 2, 3, 15, 0, 2, 1};
        bit did_reset = 0;

        rst_n = 0; frame_tick = 0; enable = 1; density = 4'd15;
        rd_col = 7'd0; rd_row = 6'd0;
        cycle();
        cycle();
        rst_n = 1;

        // First frame at full density from the reset seed, then scan row 0
        frame_tick = 1;
        cycle();
        frame_tick = 0;
        for (int i = 0; i < 2 * NC + 10; i++) begin
            rd_col = 7'(i % NC);
            rd_row = 6'd0;
            cycle();
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            frame_tick = ($urandom_range(0, 39) == 0);
            enable     = ($urandom_range(0, 7) != 0);
            if (!m_busy && $urandom_range(0, 149) == 0)
                density = 4'(dens_tab[$urandom_range(0, 7)]);
            pick_read();
            if (!did_reset && cyc > NCYC / 2 && m_busy && m_age == 40) begin
                rst_n = 0;
                did_reset = 1;
            end else begin
                rst_n = 1;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rain_column_scheduler.md
# rain_column_scheduler

Frame-rate scheduler for the glyph-rain effect. It holds one drop slot per 8-pixel text column: active flag, head row, speed and phase. Once per frame, during vertical blanking, it sweeps every column to advance, retire or spawn drops. The pixel pipeline queries it through a 1-cycle-latency read port to get per-cell trail distance, which it maps through the colour palette ahead of the glyph ROM AND.

## Interface
Parameters:
- NUM_COLS, 80, number of text columns (640/8)
- ROWS, 40, number of glyph rows (480/12)
- TRAIL, 8, trail length in rows, including the head
- SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  single-cycle pulse at vsync start, already synchronous to clk
- enable  in  1  1 = sweeps allowed; read port works regardless
- density  in  4  spawn threshold; spawn when lfsr[3:0] < density
- rd_col  in  7  queried column, 0..NUM_COLS-1
- rd_row  in  6  queried glyph row, 0..ROWS-1
- rd_hit  out  1  cell lies within an active trail
- rd_dist  out  3  head_row - rd_row when rd_hit, else 0
- rd_head  out  1  rd_hit and rd_dist==0
- busy  out  1  sweep in progress
- overrun  out  1  sticky: frame_tick arrived while busy
- frame_cnt  out  11  count of completed sweeps, wraps at 2047

## Operation
- Slot state: active (1 bit), head (6 bits, 0..ROWS+TRAIL-1), speed (2 bits), phase (2 bits).
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on frame_tick & enable. Sets idx=0.
  - SWEEP: processes slot idx each cycle. idx==NUM_COLS-1 -> DONE.
  - DONE: lasts 1 cycle. frame_cnt+1, then -> IDLE.
- Per-slot update when active:
  - If phase==speed: phase=0 and head steps. When head==ROWS+TRAIL-1, the slot goes inactive instead (trail fully off-screen); otherwise head+1.
  - Otherwise phase+1.
  - Result: speed 0 moves every frame, speed 3 moves every 4th frame.
- Per-slot update when inactive: if lfsr[3:0] < density, spawn with active=1, head=0, speed=lfsr[5:4], phase=0. density=0 never spawns; density=15 spawns unless lfsr[3:0]==15.
- LFSR: 8-bit Fibonacci. Shift left with feedback b7^b5^b4^b3 into bit 0. Steps exactly once per SWEEP cycle and holds otherwise.
- Read port:
  - Trail distance t = head - rd_row, 6-bit unsigned.
  - rd_hit = active & (head >= rd_row) & (t < TRAIL).
  - Outputs are registered.
  - rd_col >= NUM_COLS yields rd_hit=0.
- Boundary rules:
  - frame_tick while busy: ignored, sets overrun.
  - frame_tick with enable=0: ignored, does not set overrun.
  - enable falling during a sweep does not abort it.
  - A read of the slot being written in the same cycle returns the old value.
- Reset: all slots inactive, lfsr=SEED, FSM=IDLE, idx=0. All outputs 0: rd_hit, rd_dist, rd_head, busy, overrun, frame_cnt.
- Reset mid-sweep: the sweep is abandoned and every slot is cleared.

## Timing
- Read latency: 1 clk from rd_col/rd_row to rd_*. The pixel pipeline presents rd_col/rd_row one pixel early.
- busy rises the cycle after frame_tick and stays high for NUM_COLS+1 cycles (SWEEP+DONE); 81 cycles at default.
- frame_cnt increments on the DONE->IDLE edge.
- The sweep fits within vertical blanking: 81 cycles is far below 45 lines × 800 clk.
- Slot writes take effect on the clock edge ending the slot's SWEEP cycle.

## Structure
- Package rain_pkg: ROWS, TRAIL, NUM_COLS defaults, slot struct (active/head/speed/phase), FSM state enum, LFSR tap mask.
- Sub-module lfsr8 (clk, rst_n, step, seed -> q[7:0]). The slot array lives in the top module as flops.

## Test plan
- Reset: hold rst_n=0 for 2 clks -> all outputs 0; querying any col/row gives rd_hit=0; lfsr=8'hA5.
- Spawn: density=15, SEED=8'hA5, one frame_tick -> busy high for 81 cycles, frame_cnt=1. Every column whose LFSR draw had [3:0]!=15 now reads rd_head=1 at row 0.
- Motion: force col 5 to active, head=0, speed=2 -> head reaches 1 after 3 frame_ticks and 2 after 6. At head 2, row 0 reads rd_dist=2 and row 3 reads rd_hit=0.
- Retire: col 0 with speed 0 and head=46, density=0 -> after 1 tick head=47 and row 39 reads rd_dist=8→rd_hit=0 (t ≥ TRAIL). After the next tick the slot is inactive and stays so.
- Overrun: frame_tick, then a second frame_tick 10 cycles later -> overrun=1, frame_cnt=1, sweep length unchanged. enable=0 plus frame_tick -> busy stays 0, overrun unchanged.
- Mid-sweep reset: assert rst_n=0 at SWEEP idx=40 -> next cycle busy=0, all slots inactive, frame_cnt=0.
